// File: rtl/gray_binary_conv_pipe.sv
// gray_binary_conv_pipe: elastic, valid/ready pipelined Gray<->binary converter with per-beat direction.
// Define GRAY_STEP_CHK_EN to flag Gray-mode inputs that move more than one bit from the previous one.
module gray_binary_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_err
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] valid_q, mode_q, err_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_d, mode_d, err_d;
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] load;
    logic              err_in;

    // Resolves chunk k (MSB-first) of a partially converted word; bits above it are already binary.
    function automatic logic [WIDTH-1:0] resolve_chunk(input logic [WIDTH-1:0] w, input int k);
        logic [WIDTH-1:0] r;
        int hi;
        int lo;
        r  = w;
        hi = WIDTH - 1 - k * CHUNK;
        lo = hi - CHUNK + 1;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
        end
        return r;
    endfunction

    // Stage k can load when any stage from k down to the output has room this cycle.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) load[k] = 1'b1;
            end
        end
    end

    assign in_ready = load[0] && !rst;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        valid_d = '0;
        mode_d  = '0;
        err_d   = '0;
        for (int k = 0; k < STAGES; k++) data_d[k] = '0;

        valid_d[0] = in_valid;
        mode_d[0]  = in_mode;
        err_d[0]   = err_in;
        data_d[0]  = in_mode ? (in_data ^ (in_data >> 1)) : resolve_chunk(in_data, 0);

        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            mode_d[k]  = mode_q[k-1];
            err_d[k]   = err_q[k-1];
            data_d[k]  = mode_q[k-1] ? data_q[k-1] : resolve_chunk(data_q[k-1], k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            mode_q  <= '0;
            err_q   <= '0;
            // NOTE: the stage data array is reset too, so out_data reads 0 after reset rather than X.
            for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            // NOTE: non-blocking so each stage captures its upstream neighbour's pre-edge value.
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        data_q[k] <= data_d[k];
                        mode_q[k] <= mode_d[k];
                        err_q[k]  <= err_d[k];
                    end
                end
            end
        end
    end

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0] last_gray_q;
    logic             hist_q;
    logic [WIDTH-1:0] step_diff;

    // More than one bit set <=> clearing the lowest set bit still leaves something.
    assign step_diff = in_data ^ last_gray_q;
    assign err_in    = hist_q && !in_mode && ((step_diff & (step_diff - WIDTH'(1))) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gray_q <= '0;
            hist_q      <= 1'b0;
        end else if (in_valid && in_ready && !in_mode) begin
            last_gray_q <= in_data;
            hist_q      <= 1'b1;
        end
    end
`else
    assign err_in = 1'b0;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];

endmodule
